// File: rtl/decode_cycle_pkg.sv
// decode_cycle_pkg: opcode, ALU, result-select and immediate encodings plus ID/EX register layout.
package decode_cycle_pkg;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_src_e;
  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    result_src_e result_src;
    alu_ctrl_e   alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } ex_t;
  function automatic logic [31:0] imm_ext(input logic [31:0] i, input imm_src_e s);
    return s == IMM_I ? {{20{i[31]}}, i[31:20]} :
           s == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
           s == IMM_B ? {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0} :
           s == IMM_J ? {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0} : '0;
  endfunction
  function automatic alu_ctrl_e alu_fn(input logic [2:0] f3, input logic sub);
    return f3 == 3'b000 ? (sub ? ALU_SUB : ALU_ADD) :
           f3 == 3'b010 ? ALU_SLT :
           f3 == 3'b110 ? ALU_OR  :
           f3 == 3'b111 ? ALU_AND : ALU_ADD;
  endfunction
endpackage

// File: rtl/decode_cycle_register_file.sv
// register_file: 32x32 register file, combinational reads with write-through bypass, x0 hardwired to zero.
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] mem_q [32];
  always_ff @(posedge clk)
    if (rst) mem_q <= '{default: '0};
    else if (we_i && waddr_i != '0) mem_q[waddr_i] <= wdata_i;
  assign rdata1_o = raddr1_i == '0 ? '0 : (we_i && raddr1_i == waddr_i) ? wdata_i : mem_q[raddr1_i];
  assign rdata2_o = raddr2_i == '0 ? '0 : (we_i && raddr2_i == waddr_i) ? wdata_i : mem_q[raddr2_i];
endmodule

// File: rtl/decode_cycle.sv
// decode_cycle: instruction decode, immediate extension, register read and ID/EX pipeline register.
module decode_cycle
  import decode_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  RdE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E
);
  logic [31:0] rd1, rd2;
  ex_t         ex_d, ex_q;
  imm_src_e    imm_src;
  register_file u_rf (
    .clk(clk), .rst(reset), .we_i(RegWriteW), .waddr_i(RDW), .wdata_i(ResultW),
    .raddr1_i(InstrD[19:15]), .raddr2_i(InstrD[24:20]), .rdata1_o(rd1), .rdata2_o(rd2)
  );
  always_comb begin
    ex_d     = '0;
    imm_src  = IMM_NONE;
    ex_d.rd1 = rd1;
    ex_d.rd2 = rd2;
    ex_d.pc  = PCD;
    ex_d.pc4 = PCPlus4D;
    ex_d.rd  = InstrD[11:7];
    ex_d.rs1 = InstrD[19:15];
    ex_d.rs2 = InstrD[24:20];
    case (InstrD[6:0])
      OP_LW:  begin ex_d.reg_write = 1'b1; ex_d.alu_src = 1'b1; ex_d.result_src = RES_MEM; imm_src = IMM_I; end
      OP_SW:  begin ex_d.mem_write = 1'b1; ex_d.alu_src = 1'b1; imm_src = IMM_S; end
      OP_R:   begin ex_d.reg_write = 1'b1; ex_d.alu_ctrl = alu_fn(InstrD[14:12], InstrD[30]); end
      OP_I:   begin ex_d.reg_write = 1'b1; ex_d.alu_src = 1'b1; ex_d.alu_ctrl = alu_fn(InstrD[14:12], 1'b0); imm_src = IMM_I; end
      OP_BEQ: begin ex_d.branch = 1'b1; ex_d.alu_ctrl = ALU_SUB; imm_src = IMM_B; end
      OP_JAL: begin ex_d.reg_write = 1'b1; ex_d.jump = 1'b1; ex_d.result_src = RES_PC4; imm_src = IMM_J; end
      default: ;
    endcase
    ex_d.imm = imm_ext(InstrD, imm_src);
  end
  always_ff @(posedge clk) ex_q <= (reset || FlushE) ? '0 : ex_d;
  assign RegWriteE   = ex_q.reg_write;
  assign MemWriteE   = ex_q.mem_write;
  assign JumpE       = ex_q.jump;
  assign BranchE     = ex_q.branch;
  assign ALUSrcE     = ex_q.alu_src;
  assign ResultSrcE  = ex_q.result_src;
  assign ALUControlE = ex_q.alu_ctrl;
  assign RD1E        = ex_q.rd1;
  assign RD2E        = ex_q.rd2;
  assign ImmExtE     = ex_q.imm;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc4;
  assign RdE         = ex_q.rd;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;
endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: scoreboard bench, reference decoder and register model vs. decode_cycle.
module tb_decode_cycle;
  logic        clk, reset, RegWriteW, FlushE;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic [4:0]  RDW;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RdE, Rs1E, Rs2E;
  typedef struct {
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rd, rs1, rs2;
    logic        rw, mw, j, b, as;
    logic [1:0]  rsrc;
    logic [2:0]  alu;
    bit          chk_imm;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] model_rf [32];
  int          checks = 0, errors = 0;
  decode_cycle dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
    end
  endtask
  function automatic logic [31:0] read_ref(input logic [4:0] a, input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 0;
    if (we && wa == a) return wd;
    return model_rf[a];
  endfunction
  function automatic exp_t decode_ref(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pc4,
                                      input logic [31:0] v1, input logic [31:0] v2);
    exp_t        e;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [12:0] bimm;
    logic [20:0] jimm;
    int          si, iimm, simm;
    op   = ins[6:0];
    f3   = ins[14:12];
    si   = ins;
    iimm = si >>> 20;
    simm = ((si >>> 25) <<< 5) | int'(ins[11:7]);
    bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    jimm = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    e = '{rd1: v1, rd2: v2, imm: 0, pc: pc, pc4: pc4, rd: ins[11:7], rs1: ins[19:15], rs2: ins[24:20],
          rw: 0, mw: 0, j: 0, b: 0, as: 0, rsrc: 0, alu: 0, chk_imm: 1};
    case (op)
      7'b0000011: begin e.rw = 1; e.as = 1; e.rsrc = 2'b01; e.imm = iimm; end
      7'b0100011: begin e.mw = 1; e.as = 1; e.imm = simm; end
      7'b0110011, 7'b0010011: begin
        e.rw = 1;
        e.as = (op == 7'b0010011);
        if (e.as) e.imm = iimm;
        case (f3)
          3'd0:    e.alu = (!e.as && ins[30]) ? 3'b001 : 3'b000;
          3'd2:    e.alu = 3'b101;
          3'd6:    e.alu = 3'b011;
          default: e.alu = 3'b010;
        endcase
      end
      7'b1100011: begin e.b = 1; e.alu = 3'b001; e.imm = int'(bimm) - (ins[31] ? 8192 : 0); end
      7'b1101111: begin e.rw = 1; e.j = 1; e.rsrc = 2'b10; e.imm = int'(jimm) - (ins[31] ? 2097152 : 0); end
      default: e.chk_imm = 0;
    endcase
    return e;
  endfunction
  task automatic step(input logic r, input logic f, input logic [31:0] ins,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] pc;
    pc        = $urandom & 32'hFFFF_FFFC;
    reset     = r;
    FlushE    = f;
    InstrD    = ins;
    PCD       = pc;
    PCPlus4D  = pc + 4;
    RegWriteW = we;
    RDW       = wa;
    ResultW   = wd;
    e = decode_ref(ins, pc, pc + 4, read_ref(ins[19:15], we, wa, wd), read_ref(ins[24:20], we, wa, wd));
    if (r || f) e = '{rd1: 0, rd2: 0, imm: 0, pc: 0, pc4: 0, rd: 0, rs1: 0, rs2: 0,
                      rw: 0, mw: 0, j: 0, b: 0, as: 0, rsrc: 0, alu: 0, chk_imm: 1};
    sb.push_back(e);
    if (r) foreach (model_rf[k]) model_rf[k] = 0;
    else if (we && wa != 0) model_rf[wa] = wd;
    @(posedge clk);
    #2;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("RegWriteE", 32'(RegWriteE), 32'(e.rw));
        chk("MemWriteE", 32'(MemWriteE), 32'(e.mw));
        chk("JumpE", 32'(JumpE), 32'(e.j));
        chk("BranchE", 32'(BranchE), 32'(e.b));
        chk("ALUSrcE", 32'(ALUSrcE), 32'(e.as));
        chk("ResultSrcE", 32'(ResultSrcE), 32'(e.rsrc));
        chk("ALUControlE", 32'(ALUControlE), 32'(e.alu));
        chk("RD1E", RD1E, e.rd1);
        chk("RD2E", RD2E, e.rd2);
        if (e.chk_imm) chk("ImmExtE", ImmExtE, e.imm);
        chk("PCE", PCE, e.pc);
        chk("PCPlus4E", PCPlus4E, e.pc4);
        chk("RdE", 32'(RdE), 32'(e.rd));
        chk("Rs1E", 32'(Rs1E), 32'(e.rs1));
        chk("Rs2E", 32'(Rs2E), 32'(e.rs2));
      end
    end
  end
  initial begin
    logic [6:0]  ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    logic [2:0]  f3s [4] = '{3'd0, 3'd2, 3'd6, 3'd7};
    logic [31:0] ins;
    int          sel;
    foreach (model_rf[k]) model_rf[k] = 0;
    step(1, 0, 32'h0052_8333, 0, 0, 0);
    step(1, 0, 32'h0052_8333, 1, 5, 32'h55);
    step(0, 0, 32'h0052_8333, 0, 0, 0);
    step(0, 0, 32'h0000_0000, 1, 5, 32'hAA);
    step(0, 0, 32'h0052_8333, 0, 0, 0);
    step(0, 0, 32'h0003_8433, 1, 7, 32'h1234);
    step(0, 0, 32'h0000_0000, 1, 0, 32'hFFFF_FFFF);
    step(0, 0, 32'h0000_00B3, 0, 0, 0);
    step(0, 0, 32'hFFC1_2083, 0, 0, 0);
    step(0, 1, 32'h0000_0463, 1, 9, 32'hDEAD_BEEF);
    step(0, 0, 32'h0000_0463, 0, 0, 0);
    step(0, 0, 32'h0004_8033, 0, 0, 0);
    step(1, 1, 32'h0052_8333, 1, 3, 32'h77);
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 7);
      ins = $urandom;
      ins[6:0]   = sel < 6 ? ops[sel] : 7'($urandom);
      ins[14:12] = f3s[$urandom_range(0, 3)];
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, ins,
           1'($urandom), 5'($urandom_range(0, 9)), $urandom);
    end
    step(0, 0, 32'h0000_0013, 0, 0, 0);
    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and the register file at 32 entries.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 InstrD, PCD, PCPlus4D  input  32 each  instruction, PC and PC+4 from fetch.
REQ-005 RegWriteW  input  1  writeback enable; RDW input 5 destination; ResultW input 32 writeback data.
REQ-006 FlushE  input  1  squash the ID/EX register contents on the next edge.
REQ-007 RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  output  1 each  registered controls.
REQ-008 ResultSrcE  output  2  (00 ALU, 01 memory, 10 PC+4).
REQ-009 ALUControlE  output  3  (000 add, 001 sub, 010 and, 011 or, 101 slt).
REQ-010 RD1E, RD2E, ImmExtE, PCE, PCPlus4E  output  32 each; RdE, Rs1E, Rs2E  output  5 each.

Function
REQ-011 Decode SHALL support opcodes 0000011 lw, 0100011 sw, 0110011 R-type, 0010011 I-type ALU, 1100011 beq, 1101111 jal.
REQ-012 Unsupported opcodes SHALL produce all-zero controls (NOP).
REQ-013 ALUControl: lw/sw/jal add; beq sub; R/I by funct3 (000 add, or sub when R-type and funct7[5]=1; 010 slt; 110 or; 111 and).
REQ-014 Immediate SHALL be sign-extended from InstrD[31]: I {[31:20]}, S {[31:25],[11:7]}, B {[31],[7],[30:25],[11:8],0}, J {[31],[19:12],[20],[30:21],0}; R-type ImmExt = 0.
REQ-015 Rs1 = InstrD[19:15], Rs2 = InstrD[24:20], Rd = InstrD[11:7].
REQ-016 Register file SHALL read combinationally and write ResultW to RDW on the rising edge when RegWriteW=1.
REQ-017 Writes to x0 SHALL be ignored; reads of x0 SHALL return 0.
REQ-018 Same-cycle write and read of the same nonzero register SHALL return ResultW (write-through bypass).
REQ-019 All E outputs SHALL be registered: one cycle latency from D inputs to E outputs.
REQ-020 FlushE=1 SHALL load RegWriteE, MemWriteE, JumpE, BranchE = 0 and all other E registers = 0 on that edge; register-file writes still occur.
REQ-021 Simultaneous reset and FlushE: reset wins; the register file is also cleared.

Reset
REQ-022 With reset=1 at a rising edge, all E outputs SHALL become 0 and all 32 register-file entries SHALL become 0.
REQ-023 A RegWriteW write coinciding with reset SHALL be discarded.
REQ-024 Reset asserted mid-stream SHALL squash the instruction in ID/EX; there is no recovery of in-flight state.

Structure
REQ-025 A shared package SHALL hold the opcode constants, ALUControl, ResultSrc and ImmSrc encodings.
REQ-026 The register file SHALL be a separate sub-module, register_file; control decode and immediate extension SHALL remain in decode_cycle.

Verification
REQ-027 Reset:
- Stimulus: hold reset 2 cycles with InstrD=0x00528333.
- Required response: all E outputs 0.
REQ-028 R-type read after write:
- Stimulus: write x5=0x000000AA, then InstrD=0x00528333 (add x6,x5,x5).
- Required response: next cycle RD1E=RD2E=0xAA, RdE=6, RegWriteE=1, ALUControlE=000, ALUSrcE=0.
REQ-029 Write-through bypass:
- Stimulus: in the same cycle, RegWriteW=1, RDW=7, ResultW=0x1234, and InstrD reads rs1=x7.
- Required response: RD1E=0x00001234.
REQ-030 x0 protection:
- Stimulus: write x0=0xFFFFFFFF, then add x1,x0,x0.
- Required response: RD1E=RD2E=0.
REQ-031 Load decode:
- Stimulus: InstrD=0xFFC12083 (lw x1,-4(x2)).
- Required response: ImmExtE=0xFFFFFFFC, ResultSrcE=01, ALUSrcE=1, RegWriteE=1, MemWriteE=0, RdE=1.
REQ-032 Flush:
- Stimulus: beq presented with FlushE=1.
- Required response: next cycle BranchE=0, RegWriteE=0, MemWriteE=0, JumpE=0.
